// File: rtl/mul_unit_pkg.sv
// ============================================================================
// Module : mul_unit_pkg
// Brief  : Shared opcodes, FSM state type and opcode helpers for mul_unit / HiLo
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_unit_pkg;

   localparam int unsigned OP_W  = 6;
   localparam int unsigned CNT_W = 6;

   localparam logic [OP_W-1:0] MADD  = 6'd0;
   localparam logic [OP_W-1:0] MADDU = 6'd1;
   localparam logic [OP_W-1:0] MULT  = 6'd24;
   localparam logic [OP_W-1:0] MULTU = 6'd25;
   localparam logic [OP_W-1:0] NOP   = 6'd63;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mul_state_t;

   function automatic logic is_mul_op(input logic [OP_W-1:0] opCode);
      return (opCode == MADD) || (opCode == MADDU) ||
             (opCode == MULT) || (opCode == MULTU);
   endfunction

   function automatic logic is_signed_op(input logic [OP_W-1:0] opCode);
      return (opCode == MADD) || (opCode == MULT);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mul_abs_neg.sv
// ============================================================================
// Module : mul_abs_neg
// Brief  : Combinational conditional two's-complement negate
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_abs_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_neg,
   output logic [WIDTH-1:0] o_result
);

   // Negating the most negative value wraps to itself, which reads correctly as unsigned.
   assign o_result = i_neg ? (~i_value + WIDTH'(1)) : i_value;

endmodule

`default_nettype wire

// File: rtl/mul_unit.sv
// ============================================================================
// Module : mul_unit
// Brief  : Multi-cycle radix-2 shift-add multiplier feeding the HiLo stage
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_unit
   import mul_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [5:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   MulAns,
   output logic [5:0]           MulOp
);

   localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

   mul_state_t             r_state;
   mul_state_t             w_stateNext;
   logic [5:0]             r_opCap;
   logic                   r_sign;
   logic [WIDTH-1:0]       r_mcand;
   logic [WIDTH-1:0]       r_mplier;
   logic [2*WIDTH:0]       r_accum;
   logic [CNT_W-1:0]       r_count;
   logic [2*WIDTH-1:0]     r_ans;

   logic                   w_accept;
   logic                   w_signedOp;
   logic [WIDTH-1:0]       w_absA;
   logic [WIDTH-1:0]       w_absB;
   logic [WIDTH-1:0]       w_addend;
   logic [WIDTH:0]         w_sumHi;
   logic [2*WIDTH:0]       w_accNext;
   logic [2*WIDTH-1:0]     w_fixed;

   assign w_accept   = start && is_mul_op(op);
   assign w_signedOp = is_signed_op(op);

   mul_abs_neg #(.WIDTH(WIDTH)) u_absA (
      .i_value  (a),
      .i_neg    (w_signedOp & a[WIDTH-1]),
      .o_result (w_absA)
   );

   mul_abs_neg #(.WIDTH(WIDTH)) u_absB (
      .i_value  (b),
      .i_neg    (w_signedOp & b[WIDTH-1]),
      .o_result (w_absB)
   );

   mul_abs_neg #(.WIDTH(2*WIDTH)) u_fix (
      .i_value  (r_accum[2*WIDTH-1:0]),
      .i_neg    (r_sign),
      .o_result (w_fixed)
   );

   // Add into the upper half with a carry bit, then shift the whole accumulator right.
   assign w_addend  = r_mplier[0] ? r_mcand : '0;
   assign w_sumHi   = r_accum[2*WIDTH:WIDTH] + {1'b0, w_addend};
   assign w_accNext = {w_sumHi, r_accum[WIDTH-1:0]} >> 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      MulOp       = NOP;
      case (r_state)
         IDLE: begin
            if (w_accept) w_stateNext = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (r_count == c_LAST_ITER) w_stateNext = FIX;
         end
         FIX: begin
            busy        = 1'b1;
            w_stateNext = DONE;
         end
         DONE: begin
            done        = 1'b1;
            MulOp       = r_opCap;
            w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_opCap  <= '0;
         r_sign   <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_accum  <= '0;
         r_count  <= '0;
         r_ans    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_opCap  <= op;
                  r_sign   <= w_signedOp & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_mcand  <= w_absA;
                  r_mplier <= w_absB;
                  r_accum  <= '0;
                  r_count  <= '0;
               end
            end
            CALC: begin
               r_accum  <= w_accNext;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + CNT_W'(1);
            end
            FIX: begin
               r_ans <= w_fixed;
            end
            default: ;
         endcase
      end
   end

   assign MulAns = r_ans;

endmodule

`default_nettype wire

// File: tb/tb_mul_unit.sv
// ============================================================================
// Module : tb_mul_unit
// Brief  : Self-checking bench for mul_unit against a cycle-level behavioural model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_unit;
   import mul_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  op = 6'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic        done;
   logic [63:0] MulAns;
   logic [5:0]  MulOp;

   int nAsserts = 0;
   int nFails   = 0;
   bit chkEn    = 1'b0;

   mul_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .MulAns (MulAns),
      .MulOp  (MulOp)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] refProd(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      sx, sy;
      logic [63:0] ux, uy;
      if (o == MULT || o == MADD) begin
         sx = $signed(x);
         sy = $signed(y);
         return 64'(sx * sy);
      end
      ux = {32'd0, x};
      uy = {32'd0, y};
      return ux * uy;
   endfunction

   // Model: phase counts cycles since the accepting edge (0 = idle); done shows in phase 34.
   int          mPhase = 0;
   logic [5:0]  mOp    = 6'd0;
   logic [63:0] mProd  = 64'd0;
   logic [63:0] mAns   = 64'd0;

   always @(posedge clk) begin
      if (rst) begin
         mPhase <= 0;
         mAns   <= 64'd0;
      end else if (mPhase == 0) begin
         if (start && (op == MADD || op == MADDU || op == MULT || op == MULTU)) begin
            mPhase <= 1;
            mOp    <= op;
            mProd  <= refProd(op, a, b);
         end
      end else if (mPhase == 34) begin
         mPhase <= 0;
      end else begin
         if (mPhase == 33) mAns <= mProd;
         mPhase <= mPhase + 1;
      end
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      nAsserts++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chkEn) begin
         checkVal("busy",   64'(busy),  64'(mPhase >= 1 && mPhase <= 33));
         checkVal("done",   64'(done),  64'(mPhase == 34));
         checkVal("MulOp",  64'(MulOp), 64'((mPhase == 34) ? mOp : NOP));
         checkVal("MulAns", MulAns,     mAns);
      end
   end

   logic [5:0] lastOp;

   // Launch one operation; optional stray start at cycle injectAt with other operands.
   task automatic runOp(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y, input int injectAt);
      int cyc  = 0;
      bit seen = 1'b0;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         start = (cyc == injectAt);
         op    = (cyc == injectAt) ? MULT : 6'($urandom);
         a     = $urandom;
         b     = $urandom;
         if (done) begin
            seen   = 1'b1;
            lastOp = MulOp;
            checkVal("latency", 64'(cyc), 64'd34);
         end
      end
      start = 1'b0;
      if (!seen) checkVal("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic runInvalid(input logic [5:0] o);
      @(negedge clk);
      start = 1'b1; op = o; a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checkVal("invalid_busy", 64'(busy), 64'd0);
         checkVal("invalid_done", 64'(done), 64'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      int doneCnt;
      logic [5:0]  rop;
      logic [31:0] ra, rb;
      logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF};
      logic [5:0]  ops [4] = '{MADD, MADDU, MULT, MULTU};

      repeat (3) @(negedge clk);
      chkEn = 1'b1;
      checkVal("reset_busy",   64'(busy),  64'd0);
      checkVal("reset_done",   64'(done),  64'd0);
      checkVal("reset_MulAns", MulAns,     64'd0);
      checkVal("reset_MulOp",  64'(MulOp), 64'd63);
      rst = 1'b0;

      runOp(MULTU, 32'd3, 32'd5, 0);
      checkVal("lit_3x5", MulAns, 64'h0000_0000_0000_000F);
      checkVal("lit_op_multu", 64'(lastOp), 64'd25);
      runOp(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      checkVal("lit_ffxff", MulAns, 64'hFFFF_FFFE_0000_0001);
      runOp(MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      checkVal("lit_maddu", MulAns, 64'hFFFF_FFFE_0000_0001);
      checkVal("lit_op_maddu", 64'(lastOp), 64'd1);
      runOp(MULT, 32'hFFFF_FFFE, 32'd3, 10);
      checkVal("lit_m2x3", MulAns, 64'hFFFF_FFFF_FFFF_FFFA);
      runOp(MULT, 32'h8000_0000, 32'h8000_0000, 0);
      checkVal("lit_min_sq", MulAns, 64'h4000_0000_0000_0000);
      runOp(MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      checkVal("lit_m1xm1", MulAns, 64'h0000_0000_0000_0001);
      checkVal("lit_op_madd", 64'(lastOp), 64'd0);

      // Reset mid-operation at cycle 20.
      @(negedge clk);
      start = 1'b1; op = MULTU; a = 32'd1234; b = 32'd5678;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkVal("rst_busy",   64'(busy),  64'd0);
      checkVal("rst_MulAns", MulAns,     64'd0);
      checkVal("rst_MulOp",  64'(MulOp), 64'd63);
      doneCnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) doneCnt++;
      end
      checkVal("rst_no_done", 64'(doneCnt), 64'd0);

      runInvalid(6'd5);

      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            runInvalid(6'($urandom_range(2, 23)));
         end else begin
            rop = ops[$urandom_range(0, 3)];
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            runOp(rop, ra, rb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 35)) : 0);
         end
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

`default_nettype wire
